// File: rtl/uart_tx_feeder_pkg.sv
// Shared MiniUART register map, LSR bit positions and feeder FSM encoding.
package uart_tx_feeder_pkg;

  localparam logic [2:0] OFF_UART_DATA = 3'd0;
  localparam logic [2:0] OFF_UART_LSR  = 3'd1;

  // Transmitter-idle flag in the line status register.
  localparam int unsigned LSR_TS_BIT = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POLL,
    ST_WRITE,
    ST_GAP
  } feeder_state_e;

endpackage

// File: rtl/uart_tx_feeder_fifo.sv
// byte_fifo: circular byte buffer with occupancy count; full pushes are dropped.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is never cleared; reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and feeds them to a MiniUART over WISHBONE, polling LSR before each DATA write.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GAP   = 2
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic                   push,
  input  logic [7:0]             push_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic [4:2]             ADD_O,
  output logic [31:0]            DAT_O,
  input  logic [31:0]            DAT_I,
  output logic                   STB_O,
  output logic                   WE_O,
  input  logic                   ACK_I
);

  localparam logic [3:0] GAP_LD = 4'(GAP);

  feeder_state_e state;
  logic [3:0]    gap_cnt;
  logic          pop;
  logic [7:0]    head;
  logic          unused_dat;

  assign unused_dat = ^{DAT_I[31:LSR_TS_BIT+1], DAT_I[LSR_TS_BIT-1:0]};
  assign pop        = (state == ST_WRITE) && STB_O && ACK_I;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK_I),
    .rst       (RST_I),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge CLK_I) begin
    if (RST_I)             ovf <= 1'b0;
    else if (push && full) ovf <= 1'b1;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state   <= ST_IDLE;
      STB_O   <= 1'b0;
      WE_O    <= 1'b0;
      ADD_O   <= OFF_UART_LSR;
      DAT_O   <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            state <= ST_POLL;
            STB_O <= 1'b1;
          end
        end
        ST_POLL: begin
          if (ACK_I && DAT_I[LSR_TS_BIT]) begin
            state <= ST_WRITE;
            WE_O  <= 1'b1;
            ADD_O <= OFF_UART_DATA;
            DAT_O <= {24'h0, head};
          end
        end
        ST_WRITE: begin
          if (ACK_I) begin
            state   <= ST_GAP;
            STB_O   <= 1'b0;
            WE_O    <= 1'b0;
            ADD_O   <= OFF_UART_LSR;
            DAT_O   <= '0;
            gap_cnt <= GAP_LD;
          end
        end
        ST_GAP: begin
          // Leaving when the count hits 0 keeps the strobe low for exactly GAP cycles.
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt == 4'd1) begin
            if (!empty) begin
              state <= ST_POLL;
              STB_O <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in bytes; power of two, 2..64.
REQ-002 Parameter GAP, default 2, idle cycles between a DATA write and the next LSR poll; range 1..15.
REQ-003 CLK_I  input  1  single clock; all state changes on the rising edge.
REQ-004 RST_I  input  1  reset, synchronous, active-high.
REQ-005 push  input  1  byte-push strobe from the producer.
REQ-006 push_data  input  8  byte to enqueue.
REQ-007 full  output  1  FIFO holds DEPTH bytes.
REQ-008 empty  output  1  FIFO holds 0 bytes.
REQ-009 level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-010 ovf  output  1  sticky flag: a push was dropped.
REQ-011 ADD_O  output  [4:2]  WISHBONE address toward MiniUART.
REQ-012 DAT_O  output  32  WISHBONE write data.
REQ-013 DAT_I  input  32  WISHBONE read data.
REQ-014 STB_O  output  1  WISHBONE strobe.
REQ-015 WE_O  output  1  WISHBONE write enable.
REQ-016 ACK_I  input  1  WISHBONE acknowledge; may be combinational from STB_O.

Function
REQ-017 FIFO: circular buffer with read/write pointers; pointers wrap modulo DEPTH; level = writes - pops.
REQ-018 A push with full=1 is dropped and sets ovf, even if a pop occurs in the same cycle.
REQ-019 A push and a pop in the same cycle with full=0 both take effect; level is unchanged; a byte pushed into an empty FIFO is poppable no earlier than the next cycle.
REQ-020 FSM states: IDLE, POLL, WRITE, GAP.
REQ-021 IDLE: STB_O=0; go to POLL when empty=0.
REQ-022 POLL: STB_O=1, WE_O=0, ADD_O=OFF_UART_LSR; on ACK_I with DAT_I[5]=1 (transmitter idle), go to WRITE; on ACK_I with DAT_I[5]=0, stay in POLL and reissue the read the next cycle; without ACK_I, hold all outputs.
REQ-023 WRITE: STB_O=1, WE_O=1, ADD_O=OFF_UART_DATA, DAT_O={24'b0, FIFO head}; on ACK_I, pop the head, load the gap counter with GAP, and go to GAP; without ACK_I, hold all outputs stable.
REQ-024 GAP: STB_O=0; decrement the counter each cycle; at 0, go to POLL if empty=0, else IDLE. This lets the downstream transmitter drop its idle flag and keeps the strobe from re-triggering its load toggle.
REQ-025 DAT_O = 0 outside WRITE; ADD_O = OFF_UART_LSR outside WRITE; WE_O = 1 only in WRITE.
REQ-026 Throughput bound: at most one DATA write per GAP+2 cycles.
REQ-027 ACK_I is ignored while STB_O=0.

Reset
REQ-028 On RST_I=1 at a clock edge: FSM goes to IDLE, pointers and level are 0, ovf=0, STB_O=0, WE_O=0, DAT_O=0; FIFO contents need not be cleared.
REQ-029 Reset mid-transaction (POLL or WRITE) drops STB_O in the same edge; no pop occurs and the FIFO is emptied.
REQ-030 Reset dominates push; a push in the reset cycle is discarded.

Structure
REQ-031 OFF_UART_DATA and OFF_UART_LSR reuse the shared UART header constants; LSR_TS_BIT=5 and the FSM state encoding belong in the same shared header.
REQ-032 The FIFO is one sub-module, byte_fifo (DEPTH parameter, push/pop/full/empty/level); the FSM and WISHBONE logic stay in uart_tx_feeder.

Verification
REQ-033 Reset, then push 0x41 with a MiniUART model returning LSR=0x20 -> POLL read, WRITE with DAT_O=0x00000041 and ADD_O=OFF_UART_DATA, GAP of 2 cycles, IDLE; empty=1.
REQ-034 LSR returns 0x00 for 5 polls, then 0x20 -> exactly 6 LSR reads and one DATA write; the FIFO head is unchanged until the write ACK.
REQ-035 Push 9 bytes 0x00..0x08 with DEPTH=8 and the sink stalled -> full=1 after 8, ovf=1, level=8; draining yields 0x00..0x07 in order.
REQ-036 Simultaneous push and pop at level=3 -> level stays 3; the pointers wrap correctly across 20 sustained bytes with no loss.
REQ-037 Hold ACK_I=0 for 4 cycles in WRITE -> STB_O, WE_O, ADD_O and DAT_O are stable for all 4 cycles; the pop happens only on the ACK cycle.
REQ-038 Assert RST_I during WRITE with level=4 -> next cycle STB_O=0, level=0, ovf=0, state IDLE.
